// File: rtl/alu_pipe.sv
// alu_pipe: two-stage EX-stage ALU with valid/ready handshake.
// Holds the Z/V/N flag register; width and PADDSB lane are parameters.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int LANE  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_flags,
    output logic [2:0]       flags
);
    localparam int SHW = $clog2(WIDTH);
    localparam int HW  = WIDTH / 2;
    localparam int NL  = WIDTH / LANE;

    logic             s1_valid;
    logic [3:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic s2_free;
    logic adv;
    logic accept;

    assign s2_free  = !out_valid || out_ready;
    assign adv      = s1_valid && s2_free;
    assign in_ready = !s1_valid || s2_free;
    assign accept   = in_valid && in_ready;

    // Saturating add/sub; SUB is a + ~b + 1
    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] raw;
    logic             ovf;
    logic [WIDTH-1:0] sat;

    assign sub   = (s1_op == 4'd1);
    assign b_eff = sub ? ~s1_b : s1_b;
    assign raw   = s1_a + b_eff + {{(WIDTH-1){1'b0}}, sub};
    assign ovf   = (s1_a[WIDTH-1] == b_eff[WIDTH-1])
                && (raw[WIDTH-1] != s1_a[WIDTH-1]);
    assign sat   = !ovf ? raw
                 : raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                 : {1'b1, {(WIDTH-1){1'b0}}};

    // Half-word reduction; only the low HW+1 bits of the sum matter
    logic [HW:0]      t;
    logic [WIDTH-1:0] red;

    assign t = {1'b0, s1_a[HW-1:0]} + {1'b0, s1_b[HW-1:0]}
             + {1'b0, s1_a[WIDTH-1:HW]} + {1'b0, s1_b[WIDTH-1:HW]};
    assign red = {{(WIDTH-HW-1){t[HW]}}, t};

    // Shifts; a rotate by zero leaves a unchanged since a << WIDTH is 0
    logic [SHW-1:0]   sh;
    logic [SHW:0]     rsh;
    logic [WIDTH-1:0] sll;
    logic [WIDTH-1:0] sra;
    logic [WIDTH-1:0] ror;

    assign sh  = s1_b[SHW-1:0];
    assign rsh = (SHW+1)'(WIDTH) - {1'b0, sh};
    assign sll = s1_a << sh;
    assign sra = $signed(s1_a) >>> sh;
    assign ror = (s1_a >> sh) | (s1_a << rsh);

    // Per-lane saturating add with no carry between lanes
    logic [WIDTH-1:0] padd;

    for (genvar g = 0; g < NL; g++) begin : g_lane
        logic [LANE-1:0] la;
        logic [LANE-1:0] lb;
        logic [LANE-1:0] ls;
        logic            lovf;
        assign la   = s1_a[g*LANE +: LANE];
        assign lb   = s1_b[g*LANE +: LANE];
        assign ls   = la + lb;
        assign lovf = (la[LANE-1] == lb[LANE-1])
                   && (ls[LANE-1] != la[LANE-1]);
        assign padd[g*LANE +: LANE] = !lovf ? ls
            : ls[LANE-1] ? {1'b0, {(LANE-1){1'b1}}}
            : {1'b1, {(LANE-1){1'b0}}};
    end

    logic [WIDTH-1:0] res;
    logic [2:0]       nflags;

    // Opcode select and next flag value {Z,V,N}
    always_comb begin
        res    = '0;
        nflags = flags;
        unique case (s1_op)
            4'd0, 4'd1: begin
                res    = sat;
                nflags = {sat == '0, ovf, sat[WIDTH-1]};
            end
            4'd2: begin
                res       = s1_a ^ s1_b;
                nflags[2] = (res == '0);
            end
            4'd3: res = red;
            4'd4: begin
                res       = sll;
                nflags[2] = (res == '0);
            end
            4'd5: begin
                res       = sra;
                nflags[2] = (res == '0);
            end
            4'd6: begin
                res       = ror;
                nflags[2] = (res == '0);
            end
            4'd7:       res = padd;
            4'd8, 4'd9: res = sat;
            default:    res = '0;
        endcase
    end

    // S1 operand register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_op    <= in_op;
            s1_a     <= in_a;
            s1_b     <= in_b;
        end else if (adv) begin
            s1_valid <= 1'b0;
        end
    end

    // S2 result register and flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
            flags      <= '0;
        end else if (adv) begin
            out_valid  <= 1'b1;
            out_result <= res;
            out_flags  <= nflags;
            flags      <= nflags;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end
endmodule
